// File: rtl/eu_xbuf_mp.sv
// Direct-mapped, multi-port consumable exchange buffer with registered per-port responses.
// Define EU_XBUF_BYPASS_EN to compile in same-cycle write-to-read forwarding.
module eu_xbuf_mp #(
    parameter int unsigned IDX_BITS = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        in_addr_i,
    input  logic [DATA_W-1:0]        in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_RD*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_RD-1:0]        req_valid_i,
    input  logic [NUM_RD-1:0]        req_consume_i,
    output logic [NUM_RD-1:0]        resp_valid_o,
    output logic [NUM_RD-1:0]        resp_hit_o,
    output logic [NUM_RD*DATA_W-1:0] resp_data_o,
    output logic [IDX_BITS:0]        count_o,
    output logic                     full_o
);

    localparam int unsigned Entries = 2 ** IDX_BITS;

    logic [Entries-1:0]       valid_q, valid_d;
    logic [ADDR_W-1:0]        tag_q [Entries];
    logic [DATA_W-1:0]        data_q [Entries];
    logic [IDX_BITS:0]        count_q, count_d;
    logic [NUM_RD-1:0]        resp_valid_q, resp_valid_d;
    logic [NUM_RD-1:0]        resp_hit_q, resp_hit_d;
    logic [NUM_RD*DATA_W-1:0] resp_data_q, resp_data_d;

    logic [IDX_BITS-1:0] wr_idx;
    logic                wr_store;
    logic                fwd_consumed;
    logic [Entries-1:0]  consumed;
    logic [IDX_BITS:0]   n_cons;
    logic [ADDR_W-1:0]   ra;
    logic [IDX_BITS-1:0] ri;

    assign wr_idx     = in_addr_i[IDX_BITS-1:0];
    assign in_ready_o = in_valid_i & ~valid_q[wr_idx] & ~flush_i;

    // Ports are walked lowest first so an earlier consume hides the entry from later ports.
    always_comb begin
        consumed     = '0;
        fwd_consumed = 1'b0;
        n_cons       = '0;
        ra           = '0;
        ri           = '0;
        resp_hit_d   = '0;
        resp_data_d  = '0;
        resp_valid_d = req_valid_i;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            ra = req_addr_i[p*ADDR_W +: ADDR_W];
            ri = ra[IDX_BITS-1:0];
            if (req_valid_i[p] && !flush_i) begin
                if (valid_q[ri] && !consumed[ri] && tag_q[ri] == ra) begin
                    resp_hit_d[p]                  = 1'b1;
                    resp_data_d[p*DATA_W +: DATA_W] = data_q[ri];
                    if (req_consume_i[p]) begin
                        consumed[ri] = 1'b1;
                        n_cons       = n_cons + (IDX_BITS+1)'(1);
                    end
                end
`ifdef EU_XBUF_BYPASS_EN
                else if (in_ready_o && !fwd_consumed && ra == in_addr_i) begin
                    resp_hit_d[p]                  = 1'b1;
                    resp_data_d[p*DATA_W +: DATA_W] = in_data_i;
                    if (req_consume_i[p]) begin
                        fwd_consumed = 1'b1;
                    end
                end
`endif
            end
        end

        // A forwarded-and-consumed write never reaches storage.
        wr_store = in_ready_o & ~fwd_consumed;
        valid_d  = valid_q & ~consumed;
        if (wr_store) begin
            valid_d[wr_idx] = 1'b1;
        end
        count_d = count_q + (IDX_BITS+1)'(wr_store) - n_cons;
        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q      <= '0;
            count_q      <= '0;
            resp_valid_q <= '0;
            resp_hit_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Payload storage is not reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            tag_q[wr_idx]  <= in_addr_i;
            data_q[wr_idx] <= in_data_i;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_hit_o   = resp_hit_q;
    assign resp_data_o  = resp_data_q;
    assign count_o      = count_q;
    // Count never exceeds Entries, so its top bit is set only when full.
    assign full_o       = count_q[IDX_BITS];

endmodule

// File: tb/tb_eu_xbuf_mp.sv
// Bench for eu_xbuf_mp: directed vector table, reset/multi-hit sequences and random traffic
// checked against an entry-array reference model. Honours EU_XBUF_BYPASS_EN if defined.
module tb_eu_xbuf_mp;

    localparam int IDX_BITS = 2;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;
    localparam int NUM_RD   = 2;
    localparam int ENTRIES  = 4;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     flush_i;
    logic [ADDR_W-1:0]        in_addr_i;
    logic [DATA_W-1:0]        in_data_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [NUM_RD*ADDR_W-1:0] req_addr_i;
    logic [NUM_RD-1:0]        req_valid_i;
    logic [NUM_RD-1:0]        req_consume_i;
    logic [NUM_RD-1:0]        resp_valid_o;
    logic [NUM_RD-1:0]        resp_hit_o;
    logic [NUM_RD*DATA_W-1:0] resp_data_o;
    logic [IDX_BITS:0]        count_o;
    logic                     full_o;

    eu_xbuf_mp #(
        .IDX_BITS(IDX_BITS),
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flush_i      (flush_i),
        .in_addr_i    (in_addr_i),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .req_addr_i   (req_addr_i),
        .req_valid_i  (req_valid_i),
        .req_consume_i(req_consume_i),
        .resp_valid_o (resp_valid_o),
        .resp_hit_o   (resp_hit_o),
        .resp_data_o  (resp_data_o),
        .count_o      (count_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        wv;
        logic [5:0]  wa;
        logic [31:0] wd;
        logic [1:0]  rv;
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [1:0]  cons;
        logic        rdy;
        logic [1:0]  hit;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [2:0]  cnt;
        logic        full;
    } vec_t;

    vec_t vecs [14];

    // Reference model: what each slot of the buffer currently holds.
    bit          m_valid [ENTRIES];
    logic [5:0]  m_tag   [ENTRIES];
    logic [31:0] m_data  [ENTRIES];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cycle(input logic rst, input logic fl, input logic wv,
                             input logic [5:0] wa, input logic [31:0] wd, input logic [1:0] rv,
                             input logic [5:0] a0, input logic [5:0] a1, input logic [1:0] cons,
                             input int vi);
        logic              rdy;
        logic              fwd_taken;
        bit                taken [ENTRIES];
        logic [1:0]        eh;
        logic [31:0]       ed [NUM_RD];
        logic [5:0]        ra [NUM_RD];
        logic              ev;
        int                i;
        int                n;
        reset_n       = rst;
        flush_i       = fl;
        in_valid_i    = wv;
        in_addr_i     = wa;
        in_data_i     = wd;
        req_valid_i   = rv;
        req_addr_i    = {a1, a0};
        req_consume_i = cons;
        ra[0] = a0;
        ra[1] = a1;
        #1;
        i   = int'(wa) % ENTRIES;
        rdy = wv && !m_valid[i] && !fl;
        chk("in_ready", {63'd0, in_ready_o}, {63'd0, rdy});
        if (vi >= 0) chk($sformatf("vec%0d_in_ready", vi), {63'd0, in_ready_o}, {63'd0, vecs[vi].rdy});

        fwd_taken = 1'b0;
        eh        = '0;
        for (int e = 0; e < ENTRIES; e++) taken[e] = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ed[p] = '0;
            i     = int'(ra[p]) % ENTRIES;
            if (rv[p] && !fl) begin
                if (m_valid[i] && !taken[i] && m_tag[i] == ra[p]) begin
                    eh[p] = 1'b1;
                    ed[p] = m_data[i];
                    if (cons[p]) taken[i] = 1'b1;
                end
`ifdef EU_XBUF_BYPASS_EN
                else if (rdy && !fwd_taken && ra[p] == wa) begin
                    eh[p] = 1'b1;
                    ed[p] = wd;
                    if (cons[p]) fwd_taken = 1'b1;
                end
`endif
            end
        end

        @(posedge clk);
        #1;
        if (!rst || fl) begin
            for (int e = 0; e < ENTRIES; e++) m_valid[e] = 1'b0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) if (taken[e]) m_valid[e] = 1'b0;
            if (rdy && !fwd_taken) begin
                i = int'(wa) % ENTRIES;
                m_valid[i] = 1'b1;
                m_tag[i]   = wa;
                m_data[i]  = wd;
            end
        end
        n = 0;
        for (int e = 0; e < ENTRIES; e++) n += int'(m_valid[e]);
        chk("count", 64'(count_o), 64'(n));
        chk("full", {63'd0, full_o}, {63'd0, n == ENTRIES});
        for (int p = 0; p < NUM_RD; p++) begin
            ev = rst && rv[p];
            chk($sformatf("resp_valid%0d", p), {63'd0, resp_valid_o[p]}, {63'd0, ev});
            if (ev) begin
                chk($sformatf("resp_hit%0d", p), {63'd0, resp_hit_o[p]}, {63'd0, eh[p]});
                chk($sformatf("resp_data%0d", p), 64'(resp_data_o[p*DATA_W +: DATA_W]), 64'(ed[p]));
            end
        end

        if (vi >= 0) begin
            chk($sformatf("vec%0d_count", vi), 64'(count_o), 64'(vecs[vi].cnt));
            chk($sformatf("vec%0d_full", vi), {63'd0, full_o}, {63'd0, vecs[vi].full});
            chk($sformatf("vec%0d_resp_valid", vi), 64'(resp_valid_o), 64'(vecs[vi].rv));
            if (vecs[vi].rv[0]) begin
                chk($sformatf("vec%0d_hit0", vi), {63'd0, resp_hit_o[0]}, {63'd0, vecs[vi].hit[0]});
                chk($sformatf("vec%0d_data0", vi), 64'(resp_data_o[31:0]), 64'(vecs[vi].d0));
            end
            if (vecs[vi].rv[1]) begin
                chk($sformatf("vec%0d_hit1", vi), {63'd0, resp_hit_o[1]}, {63'd0, vecs[vi].hit[1]});
                chk($sformatf("vec%0d_data1", vi), 64'(resp_data_o[63:32]), 64'(vecs[vi].d1));
            end
        end
    endtask

    initial begin
        //          fl wv  wa     wd             rv     a0     a1     cons  rdy hit  d0  d1  cnt full
        vecs[0]  = '{0, 1, 6'h05, 32'hA5A5,      2'b00, 6'h00, 6'h00, 2'b00, 1, 2'b00, 0, 0, 3'd1, 0};
        vecs[1]  = '{0, 0, 6'h00, 32'h0,         2'b01, 6'h05, 6'h00, 2'b00, 0, 2'b01, 32'hA5A5, 0, 3'd1, 0};
        vecs[2]  = '{0, 0, 6'h00, 32'h0,         2'b11, 6'h05, 6'h05, 2'b11, 0, 2'b01, 32'hA5A5, 0, 3'd0, 0};
        vecs[3]  = '{0, 1, 6'h05, 32'h1111,      2'b00, 6'h00, 6'h00, 2'b00, 1, 2'b00, 0, 0, 3'd1, 0};
        vecs[4]  = '{0, 1, 6'h09, 32'h2222,      2'b00, 6'h00, 6'h00, 2'b00, 0, 2'b00, 0, 0, 3'd1, 0};
        vecs[5]  = '{0, 0, 6'h00, 32'h0,         2'b10, 6'h00, 6'h09, 2'b00, 0, 2'b00, 0, 0, 3'd1, 0};
        vecs[6]  = '{0, 1, 6'h00, 32'h100,       2'b00, 6'h00, 6'h00, 2'b00, 1, 2'b00, 0, 0, 3'd2, 0};
        vecs[7]  = '{0, 1, 6'h02, 32'h102,       2'b00, 6'h00, 6'h00, 2'b00, 1, 2'b00, 0, 0, 3'd3, 0};
        vecs[8]  = '{0, 1, 6'h03, 32'h103,       2'b00, 6'h00, 6'h00, 2'b00, 1, 2'b00, 0, 0, 3'd4, 1};
        vecs[9]  = '{0, 1, 6'h04, 32'h104,       2'b00, 6'h00, 6'h00, 2'b00, 0, 2'b00, 0, 0, 3'd4, 1};
        vecs[10] = '{0, 0, 6'h00, 32'h0,         2'b01, 6'h02, 6'h00, 2'b01, 0, 2'b01, 32'h102, 0, 3'd3, 0};
        vecs[11] = '{1, 1, 6'h02, 32'hDEAD,      2'b01, 6'h00, 6'h00, 2'b00, 0, 2'b00, 0, 0, 3'd0, 0};
        vecs[12] = '{0, 0, 6'h00, 32'h0,         2'b11, 6'h00, 6'h05, 2'b00, 0, 2'b00, 0, 0, 3'd0, 0};
`ifdef EU_XBUF_BYPASS_EN
        vecs[13] = '{0, 1, 6'h07, 32'h1234,      2'b10, 6'h00, 6'h07, 2'b10, 1, 2'b10, 0, 32'h1234, 3'd0, 0};
`else
        vecs[13] = '{0, 1, 6'h07, 32'h1234,      2'b10, 6'h00, 6'h07, 2'b10, 1, 2'b00, 0, 0, 3'd1, 0};
`endif

        // Settle the DUT out of its unknown power-up state before any checking.
        reset_n       = 1'b0;
        flush_i       = 1'b0;
        in_valid_i    = 1'b0;
        in_addr_i     = '0;
        in_data_i     = '0;
        req_valid_i   = '0;
        req_addr_i    = '0;
        req_consume_i = '0;
        @(posedge clk);
        #1;

        // Reset with traffic in flight: nothing may survive it.
        run_cycle(0, 0, 1, 6'h11, 32'hBEEF, 2'b11, 6'h11, 6'h01, 2'b01, -1);
        run_cycle(1, 0, 0, 6'h00, 32'h0, 2'b00, 6'h00, 6'h00, 2'b00, -1);

        for (int v = 0; v < 14; v++) begin
            run_cycle(1, vecs[v].fl, vecs[v].wv, vecs[v].wa, vecs[v].wd, vecs[v].rv,
                      vecs[v].a0, vecs[v].a1, vecs[v].cons, v);
        end

        // Both ports share a hit; then a higher-port consume beside a lower-port plain read.
        run_cycle(1, 1, 0, 6'h00, 32'h0, 2'b00, 6'h00, 6'h00, 2'b00, -1);
        run_cycle(1, 0, 1, 6'h0A, 32'hCAFE, 2'b00, 6'h00, 6'h00, 2'b00, -1);
        run_cycle(1, 0, 0, 6'h00, 32'h0, 2'b11, 6'h0A, 6'h0A, 2'b00, -1);
        run_cycle(1, 0, 0, 6'h00, 32'h0, 2'b11, 6'h0A, 6'h0A, 2'b10, -1);
        run_cycle(1, 0, 0, 6'h00, 32'h0, 2'b11, 6'h0A, 6'h0A, 2'b11, -1);

        for (int k = 0; k < 600; k++) begin
            run_cycle(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 29) == 0),
                      logic'($urandom_range(0, 1)), 6'($urandom_range(0, 11)), $urandom,
                      2'($urandom_range(0, 3)), 6'($urandom_range(0, 11)),
                      6'($urandom_range(0, 11)), 2'($urandom_range(0, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eu_xbuf_mp.md
EU_XBUF_MP -- requirements
Module: eu_xbuf_mp

Interface
REQ-001 SHALL have parameter IDX_BITS, default 2, meaning the buffer holds 2**IDX_BITS entries.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the entry payload width.
REQ-003 SHALL have parameter ADDR_W, default 6, meaning the tag/address width; ADDR_W >= IDX_BITS.
REQ-004 SHALL have parameter NUM_RD, default 2, meaning the number of independent request ports (1..4).
REQ-005 SHALL have port clk, input, 1, the rising-edge clock.
REQ-006 SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-007 SHALL have port flush_i, input, 1, which invalidates all entries.
REQ-008 SHALL have ports in_addr_i (ADDR_W), in_data_i (DATA_W) and in_valid_i (1), inputs, forming the write channel.
REQ-009 SHALL have port in_ready_o, output, 1, which is high when the write is accepted this cycle.
REQ-010 SHALL have ports req_addr_i (NUM_RD*ADDR_W), req_valid_i (NUM_RD) and req_consume_i (NUM_RD), inputs, one slice per port.
REQ-011 SHALL have ports resp_valid_o (NUM_RD), resp_hit_o (NUM_RD) and resp_data_o (NUM_RD*DATA_W), outputs, carrying the per-port responses.
REQ-012 SHALL have port count_o, output, IDX_BITS+1, giving the number of valid entries.
REQ-013 SHALL have port full_o, output, 1, asserted when count_o == 2**IDX_BITS.

Function
REQ-014 SHALL store per entry a valid bit, a full ADDR_W tag and DATA_W data, direct-mapped by index = addr[IDX_BITS-1:0].
REQ-015 SHALL drive in_ready_o combinationally as in_valid_i & ~valid[idx(in_addr_i)] & ~flush_i; the write lands on the next edge with valid=1.
REQ-016 SHALL leave the entry unchanged on a write to an occupied index; the writer retries (no overwrite, no stall of read ports).
REQ-017 SHALL register each request: on the edge after req_valid_i[p], resp_valid_o[p] = 1, giving 1-cycle latency.
REQ-018 SHALL compute hit from pre-edge state: hit = valid[idx] & tag[idx] == req_addr; resp_data_o carries the entry data on hit and 0 on miss.
REQ-019 SHALL, on a hit with req_consume_i[p] = 1, clear the valid bit on the same edge that registers the response.
REQ-020 SHALL resolve multiple ports consuming the same index in one cycle by priority: the lowest port hits and consumes, and higher ports report a miss.
REQ-021 SHALL allow multiple non-consuming ports to hit the same entry in one cycle.
REQ-022 SHALL never let a write and a consume of the same index coincide, since a write requires invalid and a consume requires valid.
REQ-023 SHALL update count_o on each edge as count + accepted_write - number_of_consumes, with no wrap.
REQ-024 SHALL, on flush_i, clear all valid bits, set count_o to 0, accept no write and return misses for requests in that cycle.
REQ-025 SHALL not couple full_o to in_ready_o beyond index occupancy; when full, every index is occupied, so in_ready_o = 0.

Reset
REQ-026 SHALL, while reset_n = 0 at an edge, clear all valid bits and set count_o = 0, resp_valid_o = 0, resp_hit_o = 0 and resp_data_o = 0.
REQ-027 SHALL not reset tag and data storage.
REQ-028 SHALL discard any request or write in flight at reset, with no response issued after reset.

Configuration
REQ-029 SHALL use the macro EU_XBUF_BYPASS_EN to compile same-cycle write-to-read forwarding in or out.
REQ-030 SHALL, with EU_XBUF_BYPASS_EN defined, make a request that misses but whose address equals an accepted in_addr_i in the same cycle hit with in_data_i, subject to the lowest-port priority.
REQ-031 SHALL, with EU_XBUF_BYPASS_EN defined and the forwarded request consuming, not store the write and leave count_o unchanged.
REQ-032 SHALL, without EU_XBUF_BYPASS_EN, have such requests miss, with REQ-018 governing.

Verification
REQ-033 SHALL cover: write addr 0x05 data 0xA5A5 -> next cycle count_o = 1; port0 read 0x05 no consume -> resp_hit = 1, data 0xA5A5, count_o stays 1.
REQ-034 SHALL cover: ports 0 and 1 both consume 0x05 in one cycle -> port0 hit 0xA5A5, port1 miss, count_o = 0.
REQ-035 SHALL cover: write 0x05 then write 0x09 (same index 1 at IDX_BITS = 2) -> second write gets in_ready_o = 0; read 0x09 -> miss.
REQ-036 SHALL cover: fill indices 0..3 -> full_o = 1, count_o = 4; consume 0x02 -> full_o = 0, count_o = 3.
REQ-037 SHALL cover: flush_i with count_o = 3 -> count_o = 0 next cycle, and all reads miss.
REQ-038 SHALL cover: with EU_XBUF_BYPASS_EN defined, write 0x07/0x1234 while port1 consumes 0x07 -> hit 0x1234 and count_o unchanged; without the macro -> miss and count_o + 1.
